nsum_frame_rx: RTL and testbench

Serial framing front end that sits directly upstream of the N-sum stage. It hunts a one-bit-per-cycle stream for a programmable sync word, then deserialises the following payload bits MSB-first into the 3-bit operand `N`. It issues a single-cycle `N_valid` pulse per accepted frame, so its outputs connect straight onto the N-sum stage's `N`/`N_valid` inputs.

---
 rtl/nsum_pkg.sv | 25 ++
 rtl/sync_matcher.sv | 46 ++++
 rtl/nsum_frame_rx.sv | 129 ++++++++++++
 tb/tb_nsum_frame_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nsum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nsum_pkg
// Brief    : Types and constants shared by the N-sum front end and N-sum stage.
// Revision : 1.0 - initial release
// ============================================================================
package nsum_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } frame_state_t;

  localparam int          N_W          = 3;
  localparam int          SUM_W        = 4;
  localparam logic [3:0]  SYNC_DEFAULT = 4'b1011;

  // True when the bits (payload plus parity bit, zero-extended) hold an even count of ones.
  function automatic logic even_parity_ok(input logic [31:0] bits);
    return ~^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_matcher.sv
`default_nettype none
// ============================================================================
// Module   : sync_matcher
// Brief    : Sync-word history shift register, saturating fill count and compare.
// Revision : 1.0 - initial release
// ============================================================================
module sync_matcher #(
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(4'b1011)
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic shift_en,
  input  logic clear,
  output logic match
);

  localparam int c_cnt_w = $clog2(SYNC_LEN + 1);

  logic [SYNC_LEN-1:0] r_hist;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [SYNC_LEN-1:0] w_hist_nxt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;

  assign w_hist_nxt = (r_hist << 1) | SYNC_LEN'(bit_in);
  assign w_cnt_nxt  = (r_cnt == c_cnt_w'(SYNC_LEN)) ? r_cnt : r_cnt + 1'b1;

  // Only a fully populated history may match, so a partial fill never aliases the pattern.
  assign match = shift_en && (w_hist_nxt == SYNC_PATTERN) && (w_cnt_nxt == c_cnt_w'(SYNC_LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_cnt  <= '0;
    end else if (shift_en) begin
      r_hist <= w_hist_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nsum_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : nsum_frame_rx
// Brief    : Sync-word hunter and MSB-first payload deserialiser feeding N/N_valid.
//            Optional trailing even-parity bit when NSUM_FRAME_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module nsum_frame_rx #(
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(nsum_pkg::SYNC_DEFAULT),
  parameter int                  N_W          = nsum_pkg::N_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           din,
  input  logic           din_valid,
  output logic [N_W-1:0] N,
  output logic           N_valid,
  output logic           sync_det,
  output logic           parity_err
);

  import nsum_pkg::*;

  localparam int         c_bc_w       = (N_W > 1) ? $clog2(N_W) + 1 : 1;
  localparam logic [1:0] c_st_hunt    = HUNT;
  localparam logic [1:0] c_st_payload = PAYLOAD;
`ifdef NSUM_FRAME_PARITY_EN
  localparam logic [1:0] c_st_parity  = PARITY;
`endif

  logic [1:0]        r_state;
  logic [c_bc_w-1:0] r_bit_cnt;
  logic [N_W-1:0]    r_payload;
  logic [N_W-1:0]    r_n;
  logic              r_n_valid;
  logic              r_sync_det;
  logic              w_match;
  logic              w_shift;
  logic              w_last_bit;
  logic [N_W-1:0]    w_payload_nxt;

  assign w_shift       = din_valid && (r_state == c_st_hunt);
  assign w_last_bit    = (r_bit_cnt == c_bc_w'(N_W - 1));
  assign w_payload_nxt = (r_payload << 1) | N_W'(din);

  // A match also wipes the history so sync bits are never reused after a frame.
  sync_matcher #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync_matcher (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (din),
    .shift_en (w_shift),
    .clear    (w_match),
    .match    (w_match)
  );

`ifdef NSUM_FRAME_PARITY_EN
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_st_hunt;
      r_bit_cnt  <= '0;
      r_payload  <= '0;
      r_n        <= '0;
      r_n_valid  <= 1'b0;
      r_sync_det <= 1'b0;
`ifdef NSUM_FRAME_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_n_valid  <= 1'b0;
      r_sync_det <= 1'b0;
`ifdef NSUM_FRAME_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (din_valid) begin
        case (r_state)
          c_st_hunt: begin
            if (w_match) begin
              r_state    <= c_st_payload;
              r_bit_cnt  <= '0;
              r_payload  <= '0;
              r_sync_det <= 1'b1;
            end
          end
          c_st_payload: begin
            r_payload <= w_payload_nxt;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last_bit) begin
`ifdef NSUM_FRAME_PARITY_EN
              r_state <= c_st_parity;
`else
              r_n       <= w_payload_nxt;
              r_n_valid <= 1'b1;
              r_state   <= c_st_hunt;
`endif
            end
          end
`ifdef NSUM_FRAME_PARITY_EN
          c_st_parity: begin
            if (even_parity_ok(32'({r_payload, din}))) begin
              r_n       <= r_payload;
              r_n_valid <= 1'b1;
            end else begin
              r_parity_err <= 1'b1;
            end
            r_state <= c_st_hunt;
          end
`endif
          default: r_state <= c_st_hunt;
        endcase
      end
    end
  end

  assign N        = r_n;
  assign N_valid  = r_n_valid;
  assign sync_det = r_sync_det;

endmodule
`default_nettype wire

// File: tb/tb_nsum_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_nsum_frame_rx
// Brief    : Scoreboard bench for nsum_frame_rx against a bit-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nsum_frame_rx;

  localparam int         SYNC_LEN = 4;
  localparam int         N_W      = 3;
  localparam logic [3:0] PAT      = 4'b1011;

  localparam int EV_SYNC = 0;
  localparam int EV_NV   = 1;
  localparam int EV_PERR = 2;

  typedef struct {
    int     kind;
    int     n;
    longint cyc;
  } ev_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           din = 1'b0;
  logic           din_valid = 1'b0;
  logic [N_W-1:0] N;
  logic           N_valid;
  logic           sync_det;
  logic           parity_err;

  int     n_checks = 0;
  int     n_fail = 0;
  int     nv_seen = 0;
  int     held = 0;
  longint cyc = 0;
  ev_t    sb_q[$];

  // Reference model state: recent hunt bits, current phase, payload value so far.
  bit hq[$];
  int phase = 0;
  int pv = 0;
  int pcnt = 0;

  nsum_frame_rx #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_PATTERN (PAT),
    .N_W          (N_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .N          (N),
    .N_valid    (N_valid),
    .sync_det   (sync_det),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int n);
    ev_t e;
    e.kind = kind;
    e.n    = n;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic model_bit(input bit b);
    int v;
    int ones;
    case (phase)
      0: begin
        hq.push_back(b);
        if (hq.size() > SYNC_LEN) void'(hq.pop_front());
        if (hq.size() == SYNC_LEN) begin
          v = 0;
          foreach (hq[i]) v = v * 2 + int'(hq[i]);
          if (v == int'(PAT)) begin
            push_ev(EV_SYNC, 0);
            hq.delete();
            phase = 1;
            pv = 0;
            pcnt = 0;
          end
        end
      end
      1: begin
        pv = pv * 2 + int'(b);
        pcnt++;
        if (pcnt == N_W) begin
`ifdef NSUM_FRAME_PARITY_EN
          phase = 2;
`else
          push_ev(EV_NV, pv);
          phase = 0;
`endif
        end
      end
      default: begin
        ones = int'(b);
        for (int i = 0; i < N_W; i++) ones += (pv >> i) & 1;
        if (ones % 2 == 0) push_ev(EV_NV, pv);
        else               push_ev(EV_PERR, 0);
        phase = 0;
      end
    endcase
  endtask

  task automatic model_reset();
    hq.delete();
    sb_q.delete();
    phase = 0;
    pv = 0;
    pcnt = 0;
  endtask

  task automatic send(input bit b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    model_bit(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i] == "1");
  endtask

  task automatic do_reset();
    idle(2);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses, and tracks the held N value.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 0;
        chk("rst_N", int'(N), 0);
        chk("rst_pulses", int'({N_valid, sync_det, parity_err}), 0);
      end else begin
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          chk("missing_pulse_kind", -1, sb_q[0].kind);
          void'(sb_q.pop_front());
        end
        if (int'(N_valid) + int'(sync_det) + int'(parity_err) > 1)
          chk("pulse_overlap", int'({N_valid, sync_det, parity_err}), 0);
        if (N_valid || sync_det || parity_err) begin
          int kind_seen;
          kind_seen = N_valid ? EV_NV : (sync_det ? EV_SYNC : EV_PERR);
          if (sb_q.size() == 0) begin
            chk("unexpected_pulse_kind", kind_seen, -1);
          end else begin
            ev_t e;
            e = sb_q.pop_front();
            chk("pulse_kind", kind_seen, e.kind);
            chk("pulse_cycle", int'(cyc), int'(e.cyc));
            if (e.kind == EV_NV && kind_seen == EV_NV) held = e.n;
          end
          if (N_valid) nv_seen++;
        end
        chk("N_held", int'(N), held);
      end
    end
  end

  initial begin
    int nv0;
    int r;
    int pay;
    int ones;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    send_str("1011011");  idle(3);
    send_str("11011101"); idle(3);
    send_str("10110");    idle(3); send_str("10"); idle(3);
    send_str("101101");   do_reset();
    send_str("1011010");  idle(3);
    nv0 = nv_seen;
    send_str("1011101");  send_str("1011100"); idle(3);
    chk("reuse_nvalid_count", nv_seen - nv0, 2);
`ifdef NSUM_FRAME_PARITY_EN
    send_str("10110110"); idle(2);
    nv0 = nv_seen;
    send_str("10111101"); idle(3);
    chk("perr_no_nvalid", nv_seen - nv0, 0);
`endif

    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        do_reset();
      end else if (r < 12) begin
        for (int i = SYNC_LEN - 1; i >= 0; i--) begin
          send(PAT[i]);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        pay = $urandom_range(0, (1 << N_W) - 1);
        ones = 0;
        for (int i = N_W - 1; i >= 0; i--) begin
          send(1'((pay >> i) & 1));
          ones += (pay >> i) & 1;
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
`ifdef NSUM_FRAME_PARITY_EN
        if ($urandom_range(0, 3) == 0) send(1'($urandom_range(0, 1)));
        else                           send(1'(ones % 2));
`endif
      end else if (r < 40) begin
        idle(1);
      end else begin
        send(1'($urandom_range(0, 1)));
      end
    end

    idle(10);
    chk("queue_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
